// File: rtl/event_packer.sv
// -----------------------------------------------------------------------------
// event_packer
//   Snapshots an N_CH x DEPTH array of sample words on a trigger rising edge and
//   writes it to the event FIFO as a framed packet: header, payload, trailer.
//   FIFO backpressure stalls the packet without losing or repeating words.
//   Trigger edges arriving while a packet is in flight are counted as drops.
//
// Ports
//   clk            block clock (clk_125 domain)
//   rst            asynchronous, active-high reset
//   enable_i       1 = accept trigger edges, 0 = ignore them (not counted)
//   trigger_i      level trigger; rising edge detected internally
//   event_i        flattened samples, word (ch,k) at [(ch*DEPTH+k)*WORD_W +: WORD_W]
//   full_i         FIFO full flag
//   wr_en_o        FIFO write strobe (combinational from state and full_i)
//   din_o          FIFO write data (combinational from state and index)
//   busy_o         high whenever the packer is not idle
//   event_saved_o  one-cycle pulse in the cycle after the trailer is written
//   evt_cnt_o      completed-packet counter (wraps)
//   drop_cnt_o     dropped-trigger counter (saturates)
// -----------------------------------------------------------------------------
module event_packer #(
  parameter int WORD_W = 64,
  parameter int DEPTH  = 16,
  parameter int N_CH   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable_i,
  input  logic                         trigger_i,
  input  logic [N_CH*DEPTH*WORD_W-1:0] event_i,
  input  logic                         full_i,
  output logic                         wr_en_o,
  output logic [WORD_W-1:0]            din_o,
  output logic                         busy_o,
  output logic                         event_saved_o,
  output logic [15:0]                  evt_cnt_o,
  output logic [15:0]                  drop_cnt_o
);

  localparam int TOTAL = N_CH * DEPTH;
  localparam int SNAP_W = TOTAL * WORD_W;
  localparam int IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TOTAL - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [7:0]  N_CH_B  = 8'(N_CH);
  localparam logic [31:0] TOTAL_W = 32'(TOTAL);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HEADER  = 3'd1,
    S_PAYLOAD = 3'd2,
    S_TRAILER = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                trig_prev_q, trig_prev_d;
  logic [31:0]         ts_q, ts_d;
  logic [31:0]         ts_lat_q, ts_lat_d;
  logic [SNAP_W-1:0]   shadow_q, shadow_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [15:0]         evt_cnt_q, evt_cnt_d;
  logic [15:0]         drop_cnt_q, drop_cnt_d;
  logic                saved_q, saved_d;
  logic                busy_q, busy_d;

  logic                edge_s;
  logic                take_s;
  logic                wr_s;
  logic [WORD_W-1:0]   din_s;
  logic [63:0]         hdr_s;
  logic [63:0]         trl_s;

  // Word currently presented to the FIFO and its write strobe.
  always_comb begin
    hdr_s = {8'hA5, N_CH_B, evt_cnt_q, ts_lat_q};
    // drop count is taken live so the trailer reflects drops up to its write
    trl_s = {8'h5A, 8'h00, drop_cnt_q, TOTAL_W};
    wr_s  = 1'b0;
    din_s = {WORD_W{1'b0}};
    case (state_q)
      S_HEADER: begin
        wr_s  = ~full_i;
        din_s = WORD_W'(hdr_s);
      end
      S_PAYLOAD: begin
        wr_s  = ~full_i;
        din_s = shadow_q[32'(idx_q) * WORD_W +: WORD_W];
      end
      S_TRAILER: begin
        wr_s  = ~full_i;
        din_s = WORD_W'(trl_s);
      end
      default: begin
        wr_s  = 1'b0;
        din_s = {WORD_W{1'b0}};
      end
    endcase
  end

  // Next-state, snapshot, index and counter updates.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    ts_lat_d    = ts_lat_q;
    evt_cnt_d   = evt_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    ts_d        = ts_q + 32'd1;
    trig_prev_d = trigger_i;
    edge_s      = trigger_i & ~trig_prev_q;
    take_s      = edge_s & enable_i;

    case (state_q)
      S_IDLE: begin
        if (take_s) begin
          shadow_d = event_i;
          ts_lat_d = ts_q;
          idx_d    = {IDX_W{1'b0}};
          state_d  = S_HEADER;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_HEADER: begin
        if (wr_s) begin
          state_d = S_PAYLOAD;
        end else begin
          state_d = S_HEADER;
        end
      end
      S_PAYLOAD: begin
        if (wr_s) begin
          if (idx_q == IDX_LAST) begin
            state_d = S_TRAILER;
          end else begin
            idx_d   = idx_q + IDX_ONE;
          end
        end else begin
          state_d = S_PAYLOAD;
        end
      end
      S_TRAILER: begin
        if (wr_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_TRAILER;
        end
      end
      S_DONE: begin
        evt_cnt_d = evt_cnt_q + 16'd1;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // an accepted edge outside IDLE (DONE included) is lost, not queued
    if (take_s && (state_q != S_IDLE) && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end

    saved_d = (state_d == S_DONE);
    busy_d  = (state_d != S_IDLE);
  end

  // State and datapath registers; trig_prev resets high so a trigger held
  // through reset is not seen as an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      trig_prev_q <= 1'b1;
      ts_q        <= 32'd0;
      ts_lat_q    <= 32'd0;
      shadow_q    <= {SNAP_W{1'b0}};
      idx_q       <= {IDX_W{1'b0}};
      evt_cnt_q   <= 16'd0;
      drop_cnt_q  <= 16'd0;
      saved_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      trig_prev_q <= trig_prev_d;
      ts_q        <= ts_d;
      ts_lat_q    <= ts_lat_d;
      shadow_q    <= shadow_d;
      idx_q       <= idx_d;
      evt_cnt_q   <= evt_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      saved_q     <= saved_d;
      busy_q      <= busy_d;
    end
  end

  assign wr_en_o       = wr_s;
  assign din_o         = din_s;
  assign busy_o        = busy_q;
  assign event_saved_o = saved_q;
  assign evt_cnt_o     = evt_cnt_q;
  assign drop_cnt_o    = drop_cnt_q;

endmodule

// File: tb/tb_event_packer.sv
// -----------------------------------------------------------------------------
// tb_event_packer
//   Two packer instances: dut0 (1 channel x 16 words) and dut1 (4 x 8).
//   Expected FIFO words are queued when a trigger is issued and popped as the
//   DUT writes. Single-packet scenarios come from a vector table; drops,
//   mid-packet reset, multichannel and counter wrap are hand sequences.
// -----------------------------------------------------------------------------
module tb_event_packer;

  localparam int W  = 64;
  localparam int C0 = 1;
  localparam int D0 = 16;
  localparam int C1 = 4;
  localparam int D1 = 8;

  logic clk = 1'b0;
  always #4 clk = ~clk;

  logic               rst;
  logic               en0, trg0, full0, en1, trg1, full1;
  logic [C0*D0*W-1:0] ev0;
  logic [C1*D1*W-1:0] ev1;
  logic               wr0, busy0, sv0, wr1, busy1, sv1;
  logic [W-1:0]       din0, din1;
  logic [15:0]        evc0, drc0, evc1, drc1;

  event_packer #(.WORD_W(W), .DEPTH(D0), .N_CH(C0)) dut0 (
    .clk(clk), .rst(rst), .enable_i(en0), .trigger_i(trg0), .event_i(ev0),
    .full_i(full0), .wr_en_o(wr0), .din_o(din0), .busy_o(busy0),
    .event_saved_o(sv0), .evt_cnt_o(evc0), .drop_cnt_o(drc0));

  event_packer #(.WORD_W(W), .DEPTH(D1), .N_CH(C1)) dut1 (
    .clk(clk), .rst(rst), .enable_i(en1), .trigger_i(trg1), .event_i(ev1),
    .full_i(full1), .wr_en_o(wr1), .din_o(din1), .busy_o(busy1),
    .event_saved_o(sv1), .evt_cnt_o(evc1), .drop_cnt_o(drc1));

  typedef struct {
    bit en;
    int seed;
    int stall_at;   // -1 = header, 0.. = payload index, -99 = none
    int stall_len;
    int exp_wr;
    int exp_sv;
  } vec_t;

  vec_t        vt [5];
  int          total = 0;
  int          bad = 0;
  logic [63:0] q0 [$];
  logic [63:0] q1 [$];
  int          nwr0, nwr1, nsv0, nsv1;
  logic [31:0] ts_m;
  logic [15:0] exp_evt0, exp_drop0, exp_evt1, exp_drop1;
  logic        s_wr0, s_sv0, s_busy0;
  logic [63:0] s_din0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One clock: sample/score at negedge, then advance past the posedge.
  task automatic tick();
    @(negedge clk);
    s_wr0 = wr0; s_din0 = din0; s_sv0 = sv0; s_busy0 = busy0;
    if (sv0) nsv0++;
    if (sv1) nsv1++;
    if (wr0) begin
      nwr0++;
      if (q0.size() == 0) begin
        total++; bad++;
        $display("FAIL dut0_extra_write: got din=%h want no write", din0);
      end else begin
        check("dut0_word", din0, q0.pop_front());
      end
    end
    if (wr1) begin
      nwr1++;
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL dut1_extra_write: got din=%h want no write", din1);
      end else begin
        check("dut1_word", din1, q1.pop_front());
      end
    end
    @(posedge clk);
    if (rst) ts_m = 32'd0;
    else     ts_m = ts_m + 32'd1;
    #1;
  endtask

  task automatic load_ev0(input int seed);
    for (int k = 0; k < D0; k++) begin
      logic [63:0] w;
      case (seed)
        0:       w = 64'(k + 1);
        1:       w = {32'hCAFE_0000 + 32'(k), 32'(k * 3)};
        default: w = {$urandom, $urandom};
      endcase
      ev0[k*W +: W] = w;
    end
  endtask

  task automatic push_pkt0(input logic [15:0] evc, input logic [31:0] ts,
                           input logic [15:0] drops, input int n_pay, input bit with_trl);
    q0.push_back({8'hA5, 8'h01, evc, ts});
    for (int k = 0; k < n_pay; k++) q0.push_back(ev0[k*W +: W]);
    if (with_trl) q0.push_back({8'h5A, 8'h00, drops, 32'd16});
  endtask

  task automatic check_idle0(input string tag, input int exp_wr, input int exp_sv);
    check({tag, "_writes"}, 64'(nwr0), 64'(exp_wr));
    check({tag, "_saved"}, 64'(nsv0), 64'(exp_sv));
    check({tag, "_queue"}, 64'(q0.size()), 64'd0);
    check({tag, "_evt_cnt"}, 64'(evc0), 64'(exp_evt0));
    check({tag, "_drop_cnt"}, 64'(drc0), 64'(exp_drop0));
    check({tag, "_busy"}, 64'(busy0), 64'd0);
  endtask

  initial begin
    int stall_left;
    vt[0] = '{1'b1, 0, -99, 0, 18, 1};
    vt[1] = '{1'b1, 1,   3, 5, 18, 1};
    vt[2] = '{1'b0, 2, -99, 0,  0, 0};
    vt[3] = '{1'b1, 2,  15, 1, 18, 1};
    vt[4] = '{1'b1, 1,  -1, 3, 18, 1};

    // reset with trigger held high: must not be seen as an edge afterwards
    rst = 1'b1; en0 = 1'b1; trg0 = 1'b1; full0 = 1'b0; ev0 = '0;
    en1 = 1'b1; trg1 = 1'b0; full1 = 1'b0; ev1 = '0;
    ts_m = 32'd0; nwr0 = 0; nwr1 = 0; nsv0 = 0; nsv1 = 0;
    exp_evt0 = 16'd0; exp_drop0 = 16'd0; exp_evt1 = 16'd0; exp_drop1 = 16'd0;
    tick(); tick();
    check("rst_wr_en", 64'(wr0), 64'd0);
    check("rst_din", din0, 64'd0);
    check("rst_busy", 64'(busy0), 64'd0);
    check("rst_saved", 64'(sv0), 64'd0);
    check("rst_evt_cnt", 64'(evc0), 64'd0);
    check("rst_drop_cnt", 64'(drc0), 64'd0);
    check("rst_busy1", 64'(busy1), 64'd0);
    rst = 1'b0;
    tick(); tick(); tick();
    check_idle0("held_trigger", 0, 0);
    trg0 = 1'b0;
    tick();

    for (int v = 0; v < 5; v++) begin
      nwr0 = 0; nsv0 = 0;
      load_ev0(vt[v].seed);
      en0 = vt[v].en;
      if (v == 0) begin
        for (int i = 0; i < 20 && ts_m < 32'd10; i++) tick();
      end
      if (vt[v].en) push_pkt0(exp_evt0, ts_m, exp_drop0, D0, 1'b1);
      trg0 = 1'b1;
      tick();
      // later edges arrive with enable low; snapshot must ignore new samples
      en0 = 1'b0;
      ev0 = ~ev0;
      stall_left = vt[v].stall_len;
      for (int c = 0; c < 32; c++) begin
        trg0  = (c < 20) && ((c / 2) % 2 == 1);
        full0 = (stall_left > 0) && (nwr0 == vt[v].stall_at + 1);
        if (full0) stall_left--;
        tick();
        if (v == 0 && c == 0) check("basic_header", s_din0, 64'hA501_0000_0000_000A);
        if (full0) begin
          check("stall_wr_en", 64'(s_wr0), 64'd0);
          check("stall_din_hold", s_din0, (q0.size() > 0) ? q0[0] : 64'd0);
        end
      end
      full0 = 1'b0; trg0 = 1'b0;
      if (vt[v].en) exp_evt0 = exp_evt0 + 16'd1;
      check_idle0($sformatf("vec%0d", v), vt[v].exp_wr, vt[v].exp_sv);
    end

    // drops: three edges mid-packet, one in the DONE cycle
    en0 = 1'b1; nwr0 = 0; nsv0 = 0;
    load_ev0(2);
    push_pkt0(exp_evt0, ts_m, 16'd3, D0, 1'b1);
    for (int c = 0; c < 26; c++) begin
      trg0 = (c <= 1) || (c == 3) || (c == 5) || (c == 7) || (c >= 19);
      tick();
      if (c == 19) check("done_pulse_t19", 64'(s_sv0), 64'd1);
    end
    exp_evt0 = exp_evt0 + 16'd1;
    exp_drop0 = 16'd4;
    check_idle0("drops", 18, 1);
    check("drop_cnt_4", 64'(drc0), 64'd4);
    trg0 = 1'b0; tick();
    nwr0 = 0; nsv0 = 0;
    push_pkt0(exp_evt0, ts_m, 16'd4, D0, 1'b1);
    trg0 = 1'b1; tick(); trg0 = 1'b0;
    for (int c = 0; c < 24; c++) tick();
    exp_evt0 = exp_evt0 + 16'd1;
    check_idle0("after_drops", 18, 1);

    // reset at payload index 5
    nwr0 = 0; nsv0 = 0;
    load_ev0(1);
    push_pkt0(exp_evt0, ts_m, exp_drop0, 5, 1'b0);
    trg0 = 1'b1; tick(); trg0 = 1'b0;
    for (int c = 1; c <= 6; c++) tick();
    rst = 1'b1;
    tick();
    check("midrst_wr_en", 64'(s_wr0), 64'd0);
    check("midrst_busy", 64'(s_busy0), 64'd0);
    check("midrst_evt_cnt", 64'(evc0), 64'd0);
    check("midrst_drop_cnt", 64'(drc0), 64'd0);
    check("midrst_writes", 64'(nwr0), 64'd6);
    rst = 1'b0;
    exp_evt0 = 16'd0; exp_drop0 = 16'd0; exp_evt1 = 16'd0; exp_drop1 = 16'd0;
    tick();
    nwr0 = 0; nsv0 = 0;
    load_ev0(2);
    push_pkt0(exp_evt0, ts_m, exp_drop0, D0, 1'b1);
    trg0 = 1'b1; tick(); trg0 = 1'b0;
    for (int c = 0; c < 24; c++) tick();
    exp_evt0 = exp_evt0 + 16'd1;
    check_idle0("post_rst", 18, 1);

    // multichannel packet on dut1
    nwr1 = 0; nsv1 = 0;
    for (int ch = 0; ch < C1; ch++)
      for (int k = 0; k < D1; k++)
        ev1[(ch*D1+k)*W +: W] = 64'(ch * 256 + k);
    q1.push_back({8'hA5, 8'h04, exp_evt1, ts_m});
    for (int i = 0; i < C1*D1; i++) q1.push_back(ev1[i*W +: W]);
    q1.push_back({8'h5A, 8'h00, exp_drop1, 32'd32});
    trg1 = 1'b1; tick(); trg1 = 1'b0;
    ev1 = ~ev1;
    for (int c = 0; c < 40; c++) tick();
    check("mc_writes", 64'(nwr1), 64'd34);
    check("mc_saved", 64'(nsv1), 64'd1);
    check("mc_queue", 64'(q1.size()), 64'd0);
    check("mc_evt_cnt", 64'(evc1), 64'd1);

    // packet counter wrap
    force dut0.evt_cnt_q = 16'hFFFF;
    tick();
    release dut0.evt_cnt_q;
    tick();
    check("wrap_preload", 64'(evc0), 64'hFFFF);
    exp_evt0 = 16'hFFFF;
    nwr0 = 0; nsv0 = 0;
    load_ev0(0);
    push_pkt0(exp_evt0, ts_m, exp_drop0, D0, 1'b1);
    trg0 = 1'b1; tick(); trg0 = 1'b0;
    for (int c = 0; c < 24; c++) tick();
    exp_evt0 = exp_evt0 + 16'd1;
    check_idle0("wrap", 18, 1);
    check("wrap_evt_zero", 64'(evc0), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
